// File: rtl/pcpi_link_pkg.sv
// Shared definitions for the PCPI nibble link (instruction receiver and result transmitter).
// Holds the handshake FSM encoding and the default word/nibble geometry.
package pcpi_link_pkg;

  localparam int LINK_DATA_W   = 32;
  localparam int LINK_NIB_W    = 4;
  localparam int NIBS_PER_WORD = LINK_DATA_W / LINK_NIB_W;
  localparam int IDX_W         = $clog2(NIBS_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_FINISH  = 2'd3
  } link_state_t;

endpackage

// File: rtl/pcpi_result_nibble_tx.sv
// Serialises a captured PCPI result as nibbles, LSB first, over a 4-phase strobe/ack link.
// Results arriving mid-transfer are dropped (sticky ovf); a stalled phase aborts after TIMEOUT cycles (sticky tmo).
module pcpi_result_nibble_tx
  import pcpi_link_pkg::*;
#(
  parameter int DATA_W  = LINK_DATA_W,
  parameter int NIB_W   = LINK_NIB_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              res_valid,
  input  logic              res_wr,
  input  logic [DATA_W-1:0] res_data,
  input  logic              host_ack,
  input  logic              clr_err,
  output logic [NIB_W-1:0]  nib_out,
  output logic              nib_strobe,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              tmo
);

  localparam int NIBS = DATA_W / NIB_W;
  localparam int IDXW = (NIBS == NIBS_PER_WORD) ? IDX_W : ((NIBS > 1) ? $clog2(NIBS) : 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBS - 1);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  link_state_t       r_state;
  link_state_t       w_next;
  logic [DATA_W-1:0] r_word;
  logic [IDXW-1:0]   r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_done;
  logic              r_ovf;
  logic              r_tmo;

  logic w_fin_exit;
  logic w_accept;
  logic w_collide;
  logic w_tmo_hit;
  logic w_tmo_abort;
  logic w_advance;

  // FINISH exits only on ack release; that same cycle may take a new result.
  assign w_fin_exit = (r_state == ST_FINISH) && !host_ack;
  assign w_accept   = res_valid && res_wr && ((r_state == ST_IDLE) || w_fin_exit);
  assign w_collide  = res_valid && res_wr && (r_state != ST_IDLE) && !w_fin_exit;
  assign w_tmo_hit  = (TIMEOUT != 0) && (r_state != ST_IDLE) && (r_cnt == CNT_LAST);
  assign w_advance  = (r_state == ST_PRESENT) && host_ack && (r_idx != LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Handshake progress always beats the timeout in the same cycle.
  always_comb begin
    w_next      = r_state;
    w_tmo_abort = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_SETUP;
      end
      ST_SETUP: begin
        if (!host_ack) begin
          w_next = ST_PRESENT;
        end else if (w_tmo_hit) begin
          w_next      = ST_IDLE;
          w_tmo_abort = 1'b1;
        end
      end
      ST_PRESENT: begin
        if (host_ack) begin
          w_next = (r_idx == LAST_IDX) ? ST_FINISH : ST_SETUP;
        end else if (w_tmo_hit) begin
          w_next      = ST_IDLE;
          w_tmo_abort = 1'b1;
        end
      end
      ST_FINISH: begin
        if (!host_ack) begin
          w_next = w_accept ? ST_SETUP : ST_IDLE;
        end else if (w_tmo_hit) begin
          w_next      = ST_IDLE;
          w_tmo_abort = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    nib_strobe = (r_state == ST_PRESENT);
    busy       = (r_state != ST_IDLE);
    nib_out    = r_word[NIB_W-1:0];
    done       = r_done;
    ovf        = r_ovf;
    tmo        = r_tmo;
  end

  // The word is shifted only as PRESENT closes, so nib_out is frozen while strobe is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (w_accept) begin
      r_word <= res_data;
      r_idx  <= '0;
    end else if (w_advance) begin
      r_word <= r_word >> NIB_W;
      r_idx  <= r_idx + IDXW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_cnt <= '0;
    else if ((w_next != r_state) || !busy)        r_cnt <= '0;
    else                                          r_cnt <= r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
      r_tmo  <= 1'b0;
    end else begin
      r_done <= w_fin_exit;
      if (w_collide)    r_ovf <= 1'b1;
      else if (clr_err) r_ovf <= 1'b0;
      if (w_tmo_abort)  r_tmo <= 1'b1;
      else if (clr_err) r_tmo <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcpi_result_nibble_tx.sv
// Directed and randomized bench for pcpi_result_nibble_tx with a host ack model and
// a nibble-order reference derived directly from the captured words.
module tb_pcpi_result_nibble_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        res_valid = 1'b0;
  logic        res_wr = 1'b0;
  logic [31:0] res_data = '0;
  logic        host_ack = 1'b0;
  logic        clr_err = 1'b0;
  logic [3:0]  nib_out;
  logic        nib_strobe;
  logic        busy;
  logic        done;
  logic        ovf;
  logic        tmo;

  localparam int H_AUTO  = 0;
  localparam int H_HOLD  = 1;
  localparam int H_NEVER = 2;
  localparam int H_RAND  = 3;

  int         n_cmp = 0;
  int         n_err = 0;
  int         host_mode = H_AUTO;
  int         done_cnt = 0;
  int         viol = 0;
  logic [3:0] got_q[$];
  logic       prev_s = 1'b0;
  logic [3:0] prev_n = '0;

  pcpi_result_nibble_tx #(.DATA_W(32), .NIB_W(4), .TIMEOUT(255)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .res_valid  (res_valid),
    .res_wr     (res_wr),
    .res_data   (res_data),
    .host_ack   (host_ack),
    .clr_err    (clr_err),
    .nib_out    (nib_out),
    .nib_strobe (nib_strobe),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf),
    .tmo        (tmo)
  );

  initial forever #5 clk = ~clk;

  // Host: answers strobe level with ack level, optionally lazily, held high or silent.
  initial forever begin
    @(negedge clk);
    case (host_mode)
      H_AUTO:  host_ack = nib_strobe;
      H_HOLD:  host_ack = 1'b1;
      H_NEVER: host_ack = 1'b0;
      default: if ($urandom_range(0, 2) != 0) host_ack = nib_strobe;
    endcase
  end

  // Monitor: records one nibble per strobe rising edge, counts done pulses and instability.
  initial forever begin
    @(negedge clk);
    if (nib_strobe && !prev_s) got_q.push_back(nib_out);
    if (nib_strobe && prev_s && (nib_out !== prev_n)) viol++;
    if (done) done_cnt++;
    prev_s = nib_strobe;
    prev_n = nib_out;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_result(input logic [31:0] w, input logic wr);
    @(negedge clk);
    res_valid = 1'b1;
    res_wr    = wr;
    res_data  = w;
    @(negedge clk);
    res_valid = 1'b0;
    res_wr    = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  // Reference: nibble k of a word is (word >> 4k) & 0xF.
  task automatic check_word(input string tag, input logic [31:0] w, input int base);
    logic [31:0] obs;
    for (int k = 0; k < 8; k++) begin
      obs = (got_q.size() > base + k) ? {28'd0, got_q[base + k]} : 32'hXXXX_XXXX;
      check($sformatf("%s_nib%0d", tag, k), obs, (w >> (4 * k)) & 32'hF);
    end
  endtask

  initial begin
    int          n;
    int          d0;
    logic [31:0] w1;
    logic [31:0] w2;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_strobe", {31'd0, nib_strobe}, 32'd0);
    check("rst_busy",   {31'd0, busy},       32'd0);
    check("rst_done",   {31'd0, done},       32'd0);
    check("rst_flags",  {30'd0, ovf, tmo},   32'd0);
    check("rst_nib",    {28'd0, nib_out},    32'd0);
    rst_n = 1'b1;

    // Async reset in the middle of PRESENT
    drive_result(32'hCAFE_F00D, 1'b1);
    n = 0;
    while (!nib_strobe && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t1_strobe_seen", {31'd0, nib_strobe}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t1_abort_strobe", {31'd0, nib_strobe}, 32'd0);
    check("t1_abort_busy",   {31'd0, busy},       32'd0);
    check("t1_abort_other",  {29'd0, done, ovf, tmo}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    got_q.delete();

    // DEADBEEF with 1-cycle ack, capture-to-done latency
    d0 = done_cnt;
    @(negedge clk);
    res_valid = 1'b1; res_wr = 1'b1; res_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 res_valid = 1'b0; res_wr = 1'b0;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
    check("t2_done_latency", n, 32'd17);
    @(posedge clk);
    #1 check("t2_done_pulse_width", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    check("t2_done_count", done_cnt - d0, 32'd1);
    check_word("t2", 32'hDEAD_BEEF, 0);
    check("t2_nib_count", got_q.size(), 32'd8);

    // Read-only result is ignored
    got_q.delete();
    drive_result(32'h1234_5678, 1'b0);
    repeat (5) @(negedge clk);
    check("t3_busy",   {31'd0, busy}, 32'd0);
    check("t3_nibs",   got_q.size(), 32'd0);
    check("t3_ovf",    {31'd0, ovf},  32'd0);

    // Collision during 3rd nibble
    got_q.delete();
    d0 = done_cnt;
    w1 = $urandom;
    drive_result(w1, 1'b1);
    n = 0;
    while (got_q.size() < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    drive_result(32'h0000_0001, 1'b1);
    wait_done(d0 + 1, 200, "t4_done_reached");
    repeat (3) @(negedge clk);
    check("t4_ovf_set",  {31'd0, ovf}, 32'd1);
    check("t4_busy_after", {31'd0, busy}, 32'd0);
    check("t4_nib_count", got_q.size(), 32'd8);
    check_word("t4", w1, 0);
    @(negedge clk) clr_err = 1'b1;
    @(negedge clk) clr_err = 1'b0;
    check("t4_ovf_cleared", {31'd0, ovf}, 32'd0);

    // Set beats clear in the same cycle
    got_q.delete();
    d0 = done_cnt;
    drive_result($urandom, 1'b1);
    n = 0;
    while (!nib_strobe && n < 50) begin
      @(negedge clk);
      n++;
    end
    res_valid = 1'b1; res_wr = 1'b1; res_data = 32'h5555_0000; clr_err = 1'b1;
    @(negedge clk);
    res_valid = 1'b0; res_wr = 1'b0; clr_err = 1'b0;
    check("t4b_set_wins", {31'd0, ovf}, 32'd1);
    wait_done(d0 + 1, 200, "t4b_done_reached");
    @(negedge clk) clr_err = 1'b1;
    @(negedge clk) clr_err = 1'b0;

    // Host never acks: timeout after 255 cycles of PRESENT
    host_mode = H_NEVER;
    got_q.delete();
    d0 = done_cnt;
    drive_result(32'h0BAD_CAFE, 1'b1);
    n = 0;
    while (!nib_strobe && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 1;
    while (n < 400) begin
      @(negedge clk);
      if (!nib_strobe) break;
      n++;
    end
    check("t5_present_cycles", n, 32'd255);
    check("t5_tmo",   {31'd0, tmo},  32'd1);
    check("t5_busy",  {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("t5_no_done", done_cnt - d0, 32'd0);
    host_mode = H_AUTO;
    @(negedge clk);
    got_q.delete();
    w1 = $urandom;
    drive_result(w1, 1'b1);
    wait_done(d0 + 1, 200, "t5_next_done");
    check_word("t5_next", w1, 0);
    @(negedge clk) clr_err = 1'b1;
    @(negedge clk) clr_err = 1'b0;
    check("t5_tmo_cleared", {31'd0, tmo}, 32'd0);

    // Ack held high at capture
    host_mode = H_HOLD;
    @(negedge clk);
    got_q.delete();
    d0 = done_cnt;
    drive_result(32'hA5A5_A5A5, 1'b1);
    repeat (10) @(negedge clk);
    check("t6_no_strobe", got_q.size(), 32'd0);
    check("t6_waiting",   {31'd0, busy}, 32'd1);
    host_mode = H_AUTO;
    wait_done(d0 + 1, 200, "t6_done");
    check_word("t6", 32'hA5A5_A5A5, 0);
    check("t6_nib_count", got_q.size(), 32'd8);

    // Back-to-back: new result accepted in the FINISH-exit cycle
    repeat (2) @(negedge clk);
    got_q.delete();
    d0 = done_cnt;
    w1 = $urandom;
    w2 = $urandom;
    drive_result(w1, 1'b1);
    n = 0;
    while (!(busy && !nib_strobe && got_q.size() == 8) && n < 100) begin
      @(negedge clk);
      n++;
    end
    res_valid = 1'b1; res_wr = 1'b1; res_data = w2;
    @(negedge clk);
    res_valid = 1'b0; res_wr = 1'b0;
    wait_done(d0 + 2, 200, "b2b_done");
    repeat (3) @(negedge clk);
    check("b2b_ovf",   {31'd0, ovf}, 32'd0);
    check("b2b_dones", done_cnt - d0, 32'd2);
    check_word("b2b_w1", w1, 0);
    check_word("b2b_w2", w2, 8);

    // Random words with a lazy host
    host_mode = H_RAND;
    for (int it = 0; it < 6; it++) begin
      got_q.delete();
      d0 = done_cnt;
      w1 = $urandom;
      drive_result(w1, 1'b1);
      wait_done(d0 + 1, 500, $sformatf("rnd%0d_done", it));
      check_word($sformatf("rnd%0d", it), w1, 0);
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    check("rnd_flags", {30'd0, ovf, tmo}, 32'd0);
    check("strobe_stability", viol, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
